// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The state encoding and pc-update selects are used by the FSM and by pc_unit.
package fetch_seq_pkg;

  localparam int DEF_PC_W  = 8;
  localparam int DEF_IMM_W = 4;

  localparam int unsigned RESET_PC = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_ABS  = 2'd2,
    PC_REL  = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register with its next-pc mux.
// Relative offsets are sign-extended and all arithmetic wraps modulo 2^PC_W.
module pc_unit
  import fetch_seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  pc_sel_e          sel_i,
  input  logic [PC_W-1:0]  abs_i,
  input  logic [IMM_W-1:0] rel_i,
  output logic [PC_W-1:0]  pc_o
);

  logic [PC_W-1:0]         pc_q;
  logic [PC_W-1:0]         pc_d;
  logic signed [IMM_W-1:0] rel_s;
  logic signed [PC_W-1:0]  rel_ext;

  assign rel_s   = rel_i;
  assign rel_ext = PC_W'(rel_s);

  always_comb begin
    pc_d = pc_q;
    case (sel_i)
      PC_INC:  pc_d = pc_q + PC_W'(1);
      PC_ABS:  pc_d = abs_i;
      PC_REL:  pc_d = pc_q + $unsigned(rel_ext);
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: fetches one byte per instruction over a req/ready
// handshake, pulses load_ir, then applies halt/jump/branch once execution completes.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IMM_W = DEF_IMM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic             mem_req,
  output logic [PC_W-1:0]  mem_addr,
  input  logic             mem_ready,
  input  logic [7:0]       mem_data,
  output logic [7:0]       instr,
  output logic             load_ir,
  input  logic             exec_done,
  input  logic             halt,
  input  logic             jump,
  input  logic [PC_W-1:0]  jump_target,
  input  logic             branch,
  input  logic [IMM_W-1:0] branch_off,
  output logic [PC_W-1:0]  pc,
  output logic             halted
);

  state_e     state_q, state_d;
  pc_sel_e    pc_sel;
  logic [7:0] instr_q, instr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= 8'h00;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_sel  = PC_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Once issued, a fetch completes regardless of run.
        if (mem_ready) begin
          instr_d = mem_data;
          pc_sel  = PC_INC;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            if (jump)        pc_sel = PC_ABS;
            else if (branch) pc_sel = PC_REL;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  pc_unit #(
    .PC_W  (PC_W),
    .IMM_W (IMM_W)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .sel_i (pc_sel),
    .abs_i (jump_target),
    .rel_i (branch_off),
    .pc_o  (pc)
  );

  assign mem_req  = (state_q == ST_FETCH);
  assign mem_addr = mem_req ? pc : '0;
  assign load_ir  = (state_q == ST_ISSUE);
  assign halted   = (state_q == ST_HALTED);
  assign instr    = instr_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: each fetch pushes {addr,data}; the
// load_ir monitor pops it and checks instr and the incremented pc.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_data;
  logic [7:0] instr;
  logic       load_ir;
  logic       exec_done = 1'b0;
  logic       halt = 1'b0;
  logic       jump = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic       branch = 1'b0;
  logic [3:0] branch_off = 4'h0;
  logic [7:0] pc;
  logic       halted;

  logic [7:0]  mem [256];
  logic [15:0] pending [$];
  int          load_cyc [$];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  assign mem_data = mem[mem_addr];

  fetch_sequencer #(.PC_W(8), .IMM_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .instr       (instr),
    .load_ir     (load_ir),
    .exec_done   (exec_done),
    .halt        (halt),
    .jump        (jump),
    .jump_target (jump_target),
    .branch      (branch),
    .branch_off  (branch_off),
    .pc          (pc),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Load-pulse monitor: pops the scoreboard on every load_ir.
  always @(negedge clk) begin
    if (load_ir === 1'b1) begin
      load_cyc.push_back(cyc);
      if (pending.size() == 0) begin
        chk("unexpected_load_ir", 32'd1, 32'd0);
      end else begin
        logic [15:0] e;
        logic [7:0]  ea;
        e  = pending.pop_front();
        ea = e[15:8] + 8'd1;
        chk("instr", {24'd0, instr}, {24'd0, e[7:0]});
        chk("issue_pc", {24'd0, pc}, {24'd0, ea});
      end
    end
  end

  // One instruction: expected fetch address, byte, memory waits, exec delay, redirect.
  task automatic run_instr(input logic [7:0] a, input logic [7:0] d, input int waits,
                           input int done_dly, input logic h, input logic j,
                           input logic [7:0] jt, input logic b, input logic [3:0] bo,
                           input logic run_after);
    int n;
    mem[a] = d;
    pending.push_back({a, d});
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", {31'd0, mem_req}, 32'd1);
    chk("fetch_addr", {24'd0, mem_addr}, {24'd0, a});
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", {24'd0, mem_addr}, {24'd0, a});
      chk("wait_no_load", {31'd0, load_ir}, 32'd0);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    repeat (done_dly) @(negedge clk);
    exec_done   = 1'b1;
    halt        = h;
    jump        = j;
    jump_target = jt;
    branch      = b;
    branch_off  = bo;
    run         = run_after;
    @(negedge clk);
    exec_done = 1'b0;
    halt      = 1'b0;
    jump      = 1'b0;
    branch    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_instr", {24'd0, instr}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_load", {31'd0, load_ir}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    // Sequential zero-wait, then jump/wait-state/branch/wrap/priority cases.
    run = 1'b1;
    @(negedge clk);
    run_instr(8'h00, 8'h11, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    run_instr(8'h01, 8'h22, 0, 0, 1'b0, 1'b1, 8'h05, 1'b0, 4'h0, 1'b1);
    chk("rate_3cyc", load_cyc[1] - load_cyc[0], 32'd3);
    run_instr(8'h05, 8'h33, 4, 0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    run_instr(8'h06, 8'h44, 0, 1, 1'b0, 1'b1, 8'h02, 1'b0, 4'h0, 1'b1);
    run_instr(8'h02, 8'h55, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1, 4'b1110, 1'b1);
    run_instr(8'h01, 8'h66, 0, 0, 1'b0, 1'b1, 8'hFE, 1'b0, 4'h0, 1'b1);
    run_instr(8'hFE, 8'h77, 0, 0, 1'b0, 1'b0, 8'h00, 1'b1, 4'h2, 1'b1);
    run_instr(8'h01, 8'h88, 0, 2, 1'b0, 1'b1, 8'h40, 1'b1, 4'h3, 1'b1);
    run_instr(8'h40, 8'h99, 0, 0, 1'b1, 1'b1, 8'h10, 1'b1, 4'h1, 1'b1);
    chk("halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", {24'd0, pc}, 32'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_no_req", {31'd0, mem_req}, 32'd0);
    end
    chk("halt_instr_hold", {24'd0, instr}, 32'h99);

    // Reset colliding with a memory response mid-fetch.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("refetch_req", {31'd0, mem_req}, 32'd1);
    mem[0]    = 8'h5A;
    reset     = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    run       = 1'b0;
    chk("mid_rst_pc", {24'd0, pc}, 32'd0);
    chk("mid_rst_instr", {24'd0, instr}, 32'd0);
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_load", {31'd0, load_ir}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    chk("mid_rst_load2", {31'd0, load_ir}, 32'd0);
    chk("idle_no_req", {31'd0, mem_req}, 32'd0);

    // run dropped during EXEC: redirect still applied, sequencer parks in IDLE.
    run = 1'b1;
    run_instr(8'h00, 8'hAA, 0, 0, 1'b0, 1'b1, 8'h20, 1'b0, 4'h0, 1'b0);
    chk("idle_after_exec", {31'd0, mem_req}, 32'd0);
    chk("idle_pc", {24'd0, pc}, 32'h20);
    @(negedge clk);
    chk("idle_stays", {31'd0, mem_req}, 32'd0);
    run = 1'b1;
    run_instr(8'h20, 8'hBB, 0, 0, 1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0);
    chk("final_pc", {24'd0, pc}, 32'h21);
    chk("final_instr", {24'd0, instr}, 32'hBB);
    chk("scoreboard_empty", pending.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the 8-bit accumulator CPU.
- Owns the program counter and fetches one 8-bit instruction at a time from program memory over a request/ready handshake.
- Presents each instruction to the instruction register with a one-cycle load pulse.
- Waits for the controller to report execution complete, then applies halt/jump/branch redirection before the next fetch.
- Sits between program memory and the IR/controller pair, replacing the free-running external instruction input.

## Interface
Parameters:
- PC_W, 8, program counter and memory address width
- IMM_W, 4, width of the signed relative-branch offset (matches controller immediate field)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- run  in  1  level; enables starting a new fetch from IDLE
- mem_req  out  1  fetch request to program memory
- mem_addr  out  PC_W  fetch address, equals pc while mem_req high
- mem_ready  in  1  memory returns mem_data this cycle
- mem_data  in  8  instruction byte
- instr  out  8  captured instruction, to IR instruction input
- load_ir  out  1  one-cycle pulse, drives IR LoadIR
- exec_done  in  1  controller finished current instruction
- halt  in  1  qualified by exec_done; stop sequencing
- jump  in  1  qualified by exec_done; absolute redirect
- jump_target  in  PC_W  absolute target (from accumulator low bits)
- branch  in  1  qualified by exec_done; relative redirect
- branch_off  in  IMM_W  signed two's-complement offset
- pc  out  PC_W  current program counter
- halted  out  1  high in HALTED state

## Operation
States: IDLE, FETCH, ISSUE, EXEC, HALTED.
- IDLE
  - run=1 -> FETCH; else stay.
  - mem_ready is ignored.
- FETCH
  - mem_req=1 and mem_addr=pc, both held stable until mem_ready.
  - On mem_ready: instr<=mem_data, pc<=pc+1 (mod 2^PC_W), -> ISSUE.
  - run deasserting mid-fetch does not abort the fetch.
- ISSUE
  - load_ir=1 for exactly this cycle, -> EXEC.
- EXEC
  - Wait for exec_done. Inputs halt/jump/branch are sampled only when exec_done=1.
  - Priority: halt > jump > branch > sequential.
  - halt: -> HALTED, pc unchanged.
  - jump: pc<=jump_target.
  - branch: pc<=pc+sign_extend(branch_off). pc is already the address after the branch instruction. Result wraps modulo 2^PC_W.
  - After a non-halt completion: run=1 -> FETCH, else -> IDLE.
- HALTED
  - halted=1; all other outputs idle. Exits only via reset.
- Reset (any state, including mid-fetch with mem_req high)
  - Next edge: state=IDLE, pc=0, instr=0, mem_req=0, mem_addr=0, load_ir=0, halted=0.
  - A memory response arriving after reset is ignored.

## Timing
- mem_req rises the cycle after run is sampled high in IDLE.
- Zero-wait memory (mem_ready in first FETCH cycle): instr valid and load_ir high the next cycle.
- Minimum rate is 3 cycles per instruction (FETCH, ISSUE, EXEC), reached with zero-wait memory and exec_done in the first EXEC cycle.
- Each memory wait cycle adds one cycle.
- Redirected pc appears on mem_addr in the first cycle of the following FETCH.
- exec_done outside EXEC is ignored.
- instr holds its value until the next successful fetch or reset.

## Structure
- Shared package fetch_seq_pkg holds:
  - state enum (IDLE, FETCH, ISSUE, EXEC, HALTED)
  - RESET_PC constant (0)
  - default PC_W/IMM_W values
- One sub-module, pc_unit: pc register plus next-pc mux (hold / increment / absolute / sign-extended relative), with a synchronous reset to RESET_PC.
- FSM and handshake logic stay in fetch_sequencer.

## Test plan
- Reset, run=1, zero-wait memory returning 0x11, 0x22 at addresses 0, 1, exec_done one cycle after each load_ir -> mem_addr 0 then 1, load_ir pulses with instr 0x11 then 0x22, 3 cycles per instruction.
- Memory holds mem_ready low 4 cycles at address 5 -> mem_req and mem_addr=5 stable all 4 cycles, single load_ir after ready, pc=6.
- Branch at pc-after=0x03 with branch_off=4'b1110 -> next fetch at 0x01. Branch at 0xFF with offset +2 -> next fetch wraps to 0x01.
- exec_done with jump=1, jump_target=0x40, branch=1 -> next fetch at 0x40. Same cycle with halt=1 -> HALTED, pc unchanged, no further mem_req until reset.
- reset asserted while mem_req high and mem_ready arriving the same cycle -> next cycle IDLE, pc=0, instr=0, no load_ir pulse.
- run deasserted during EXEC -> returns to IDLE after exec_done with redirect applied. Reasserting run fetches from the updated pc.
